// File: rtl/prime_stream_buffer.sv
// prime_stream_buffer
//   Sits behind the 8-bit prime generator. Each accepted prime is annotated
//   with its gap from the previous prime, a twin-prime flag and a
//   first-of-sweep flag. The result is queued in a first-word-fall-through
//   FIFO and offered downstream over ready/valid. The generator cannot be
//   stalled, so a sample that arrives while the FIFO is full is dropped,
//   counted and flagged.
//
// Ports
//   clk          sole clock, posedge
//   rst          asynchronous active-high reset
//   in_prime     prime value from the generator
//   in_valid     generator strobe, one sample per high cycle
//   out_ready    downstream ready
//   out_valid    FIFO head holds data
//   out_prime    head prime
//   out_gap      head gap to previous prime (0 for first of sweep)
//   out_twin     head gap == 2
//   out_first    head is first prime of a sweep
//   level        FIFO occupancy, 0..DEPTH
//   sweep_count  completed sweeps, wrapping
//   drop_count   primes lost to a full FIFO, saturating
//   overflow     sticky, set on first drop
module prime_stream_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_prime,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [7:0]    out_prime,
  output logic [7:0]    out_gap,
  output logic          out_twin,
  output logic          out_first,
  output logic [AW:0]   level,
  output logic [7:0]    sweep_count,
  output logic [7:0]    drop_count,
  output logic          overflow
);

  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Entry layout: {prime[17:10], gap[9:2], twin[1], first[0]}
  logic [17:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [7:0]    r_last_prime;
  logic          r_has_last;
  logic [7:0]    r_sweep_count;
  logic [7:0]    r_drop_count;
  logic          r_overflow;

  logic          w_accept;
  logic          w_new_sweep;
  logic [7:0]    w_gap;
  logic          w_twin;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_valid;
  logic [17:0]   w_entry;
  logic [17:0]   w_head;

  // Classify the incoming sample and build the FIFO entry for it
  always_comb begin
    w_accept    = 1'b0;
    w_new_sweep = 1'b0;
    w_gap       = 8'd0;
    w_twin      = 1'b0;
    w_entry     = 18'd0;
    // 0 and 1 appear only when the generator counter wraps; they are not primes
    if (in_valid && (in_prime >= 8'd2)) begin
      w_accept = 1'b1;
    end else begin
      w_accept = 1'b0;
    end
    if (!r_has_last || (in_prime <= r_last_prime)) begin
      w_new_sweep = 1'b1;
      w_gap       = 8'd0;
    end else begin
      w_new_sweep = 1'b0;
      w_gap       = in_prime - r_last_prime;
    end
    w_twin  = (w_gap == 8'd2);
    w_entry = {in_prime, w_gap, w_twin, w_new_sweep};
  end

  // Push/pop handshake; a full FIFO still accepts when the head leaves this cycle
  always_comb begin
    w_valid = (r_level != {(AW+1){1'b0}});
    w_pop   = w_valid && out_ready;
    w_push  = w_accept && ((r_level < LVL_FULL) || w_pop);
    w_drop  = w_accept && !w_push;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      else        r_wr_ptr <= r_wr_ptr;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      else        r_rd_ptr <= r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head fields read 0 rather than X
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 18'd0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Stream statistics; these follow every accepted sample, dropped or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_prime  <= 8'd0;
      r_has_last    <= 1'b0;
      r_sweep_count <= 8'd0;
      r_drop_count  <= 8'd0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_prime <= in_prime;
        r_has_last   <= 1'b1;
        // A sweep is only "completed" once a previous one existed
        if (w_new_sweep && r_has_last) r_sweep_count <= r_sweep_count + 8'd1;
        else                           r_sweep_count <= r_sweep_count;
      end else begin
        r_last_prime  <= r_last_prime;
        r_has_last    <= r_has_last;
        r_sweep_count <= r_sweep_count;
      end
      if (w_drop) begin
        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
        else                       r_drop_count <= r_drop_count;
        r_overflow <= 1'b1;
      end else begin
        r_drop_count <= r_drop_count;
        r_overflow   <= r_overflow;
      end
    end
  end

  // Head fields fall through from storage at the read pointer
  assign w_head      = r_mem[r_rd_ptr];
  assign out_valid   = w_valid;
  assign out_prime   = w_head[17:10];
  assign out_gap     = w_head[9:2];
  assign out_twin    = w_head[1];
  assign out_first   = w_head[0];
  assign level       = r_level;
  assign sweep_count = r_sweep_count;
  assign drop_count  = r_drop_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_prime_stream_buffer.sv
module tb_prime_stream_buffer;

  logic       clk;
  logic       rst;
  logic [7:0] in_prime;
  logic       in_valid;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_prime;
  logic [7:0] out_gap;
  logic       out_twin;
  logic       out_first;
  logic [3:0] level;
  logic [7:0] sweep_count;
  logic [7:0] drop_count;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  logic       lvl_watch = 1'b0;
  logic [17:0] exp_q [$];

  prime_stream_buffer #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .in_prime(in_prime), .in_valid(in_valid),
    .out_ready(out_ready), .out_valid(out_valid), .out_prime(out_prime),
    .out_gap(out_gap), .out_twin(out_twin), .out_first(out_first),
    .level(level), .sweep_count(sweep_count), .drop_count(drop_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] p, input logic [7:0] g, input logic t, input logic f);
    exp_q.push_back({p, g, t, f});
  endtask

  // One-cycle generator strobe; entered and left at posedge+1
  task automatic feed(input logic [7:0] p);
    in_prime = p;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (level == 4'd0 && exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk({name, "_level"}, level, 0);
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask

  // Monitor: a pop happens at the next posedge whenever valid and ready are both high now
  always @(negedge clk) begin
    if (!rst && lvl_watch) chk("level_le1", (level <= 4'd1), 1);
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got prime %0d expected none", out_prime);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        chk("head_prime", out_prime, e[17:10]);
        chk("head_gap",   out_gap,   e[9:2]);
        chk("head_twin",  out_twin,  e[1]);
        chk("head_first", out_first, e[0]);
      end
    end
  end

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_prime", out_prime, 0);
    chk("rst_gap", out_gap, 0);
    chk("rst_twin", out_twin, 0);
    chk("rst_first", out_first, 0);
    chk("rst_level", level, 0);
    chk("rst_sweep", sweep_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ovf", overflow, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    in_prime = 8'd0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    pulse_reset();

    // Basic stream, consumer always ready
    out_ready = 1'b1;
    lvl_watch = 1'b1;
    push_exp(8'd2, 8'd0, 1'b0, 1'b1);
    push_exp(8'd3, 8'd1, 1'b0, 1'b0);
    push_exp(8'd5, 8'd2, 1'b1, 1'b0);
    push_exp(8'd7, 8'd2, 1'b1, 1'b0);
    push_exp(8'd11, 8'd4, 1'b0, 1'b0);
    push_exp(8'd13, 8'd2, 1'b1, 1'b0);
    feed(8'd2); feed(8'd3); feed(8'd5); feed(8'd7); feed(8'd11); feed(8'd13);
    drain("stream");
    lvl_watch = 1'b0;

    // Fill to full and overflow
    out_ready = 1'b0;
    pulse_reset();
    push_exp(8'd2, 8'd0, 1'b0, 1'b1);
    push_exp(8'd3, 8'd1, 1'b0, 1'b0);
    push_exp(8'd5, 8'd2, 1'b1, 1'b0);
    push_exp(8'd7, 8'd2, 1'b1, 1'b0);
    push_exp(8'd11, 8'd4, 1'b0, 1'b0);
    push_exp(8'd13, 8'd2, 1'b1, 1'b0);
    push_exp(8'd17, 8'd4, 1'b0, 1'b0);
    push_exp(8'd19, 8'd2, 1'b1, 1'b0);
    feed(8'd2); feed(8'd3); feed(8'd5); feed(8'd7); feed(8'd11);
    feed(8'd13); feed(8'd17); feed(8'd19); feed(8'd23); feed(8'd29);
    chk("full_level", level, 8);
    chk("full_drop", drop_count, 2);
    chk("full_ovf", overflow, 1);
    chk("full_valid", out_valid, 1);

    // Full with simultaneous push and pop: 31 follows 29, gap 2
    push_exp(8'd31, 8'd2, 1'b1, 1'b0);
    in_prime = 8'd31;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("pp_level", level, 8);
    chk("pp_drop", drop_count, 2);
    chk("pp_head", out_prime, 3);
    out_ready = 1'b1;
    drain("fulldrain");

    // Sweep wrap: 0 and 1 ignored, 2 starts a new sweep
    push_exp(8'd251, 8'd220, 1'b0, 1'b0);
    push_exp(8'd2, 8'd0, 1'b0, 1'b1);
    feed(8'd251); feed(8'd0); feed(8'd1); feed(8'd2);
    drain("wrap");
    chk("wrap_sweep", sweep_count, 1);
    chk("wrap_drop", drop_count, 2);

    // Reset mid-stream with 4 entries queued
    out_ready = 1'b0;
    feed(8'd3); feed(8'd5); feed(8'd7); feed(8'd11);
    chk("mid_level", level, 4);
    pulse_reset();
    out_ready = 1'b1;
    push_exp(8'd3, 8'd0, 1'b0, 1'b1);
    feed(8'd3);
    drain("after_rst");
    chk("after_rst_sweep", sweep_count, 0);
    chk("after_rst_ovf", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prime_stream_buffer.md
Name: prime_stream_buffer

Overview:
- Downstream consumer of the 8-bit prime generator.
- Samples the generator's prime/valid strobe every cycle it is asserted, annotates each prime with its gap from the previous prime, a twin-prime flag and a first-of-sweep flag, and queues the result in a first-word-fall-through FIFO.
- Presents the queue to later stages over a ready/valid interface.
- The generator has no backpressure, so this block absorbs bursts and reports drops.

Parameters:
- DEPTH, 8, number of FIFO entries (power of two, 2..64).
- AW, 3, FIFO address width; must equal log2(DEPTH).

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_prime  in  8  prime value from the generator.
- in_valid  in  1  generator strobe; every cycle it is high is one new sample.
- out_ready  in  1  downstream ready.
- out_valid  out  1  FIFO head holds data.
- out_prime  out  8  head prime.
- out_gap  out  8  head gap (in_prime minus previous prime); 0 for first of sweep.
- out_twin  out  1  head gap == 2.
- out_first  out  1  head is first prime of a sweep.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- sweep_count  out  8  completed sweeps, wraps 255->0.
- drop_count  out  8  primes lost to full FIFO, saturates at 255.
- overflow  out  1  sticky; set on first drop.

Behaviour:
- Reset (async assert, sync-safe deassert): all outputs and state are 0. This includes level, counters, overflow, head fields, last_prime and has_last.
- Sample filter: a sample with in_valid=1 and in_prime<2 is ignored entirely: no push, no stat update. This covers the generator emitting 0/1 after its 8-bit counter wraps.
- Sweep detect, for an accepted sample:
  - New sweep when has_last=0 or in_prime <= last_prime.
  - A new sweep sets first=1 and gap=0.
  - sweep_count increments if has_last was 1.
- Otherwise, for an accepted sample:
  - first=0.
  - gap = in_prime - last_prime, computed 8-bit; no underflow is possible here.
- twin = (gap == 2).
- last_prime <= in_prime and has_last <= 1 on every accepted sample, including dropped ones. Statistics track the stream, not the buffer.
- Push condition: accepted sample and (level < DEPTH or pop this cycle).
- Drop: a sample that is not pushed is dropped. On a drop:
  - drop_count increments, saturating at 255.
  - overflow <= 1.
- Pop: out_valid and out_ready in the same cycle.
- Entry storage: each FIFO entry holds {prime, gap, twin, first} (18 bits).
- FWFT: out_* reflect the head entry combinationally from storage and registered pointers.
- Latency: a sample pushed at edge N is visible with out_valid=1 in the cycle after edge N, when the FIFO was empty.
- Head stability: out_* stay stable while out_valid=1 and out_ready=0.
- level:
  - Push only: level+1.
  - Pop only: level-1.
  - Push and pop together: unchanged.
  - Pointers wrap modulo DEPTH.
- Empty: out_valid=0; out_ready is ignored; out_prime/gap/twin/first are don't-care but must not be X after reset.
- Full with simultaneous pop: push accepted, level stays DEPTH, no drop.
- Ordering: strictly FIFO; no reordering or coalescing.
- Reset mid-operation: contents are discarded immediately and level=0. The next accepted sample is treated as first of sweep with gap 0, and sweep_count is not incremented.
- No internal state machine beyond the has_last flag. The block is a push/pop controller with a pointer pair and stat registers.

Test Plan:
- Reset values: assert rst mid-cycle with no clock edge -> all outputs 0 immediately.
- Feed 2,3,5,7,11,13 with out_ready=1 -> outputs, in order:
  - (2,0,0,1), (3,1,0,0), (5,2,1,0), (7,2,1,0), (11,4,0,0), (13,2,1,0).
  - level never exceeds 1.
- Full FIFO with DEPTH=8, out_ready=0, 10 primes 2..29 -> level=8, drop_count=2, overflow=1. Then drain with out_ready=1 -> 2,3,5,7,11,13,17,19 in order, and level returns to 0.
- Full with simultaneous push and pop: level=8, in_valid=1 with 31, out_ready=1 -> pushed, level stays 8, drop_count unchanged, head advances.
- Sweep wrap: feed 251, then 0, then 1, then 2 -> 0 and 1 ignored; 2 emitted with first=1, gap=0; sweep_count=1.
- Reset mid-stream: 4 entries queued, pulse rst -> level=0, counters and overflow=0. The next prime 3 is emitted with first=1, gap=0, sweep_count=0.
